pipeline_perf_monitor: RTL and testbench
========================================

// Module: pipeline_perf_monitor
// PURPOSE
//  Synthesisable event counter and trace unit for the 5-stage pipelined CPU.
//  - Sits beside CPU and observes hazard/flush/retire/branch strobes and the IF-stage PC.
//  - Replaces ad-hoc stall/flush counting in simulation; runs on silicon too.
//  - Exposes a readable counter bank and a PC/event trace FIFO for a debug host.
// PARAMETERS
//  NUM_EVT      4    number of event inputs; event counters 0..NUM_EVT-1
//  CNT_W        32   width of the cycle counter, event counters and drop counter
//  PC_W         32   width of the traced PC
//  TRACE_DEPTH  16   trace FIFO entries; power of two, >=2
//  MAX_CYCLES   64   cycle limit that raises done_o; 0 = no limit
// PORTS
//  clk_i        in   1                    clock
//  rst_i        in   1                    synchronous active-high reset
//  start_i      in   1                    counting enable (CPU start)
//  freeze_i     in   1                    1 = hold all counters, no trace push
//  clear_i      in   1                    1-cycle pulse: zero counters, flush FIFO
//  evt_i        in   NUM_EVT              event strobes, sampled each clk_i edge
//  pc_i         in   PC_W                 current PC
//  pc_valid_i   in   1                    pc_i is a new fetch this cycle
//  rd_sel_i     in   $clog2(NUM_EVT+2)    counter read select
//  rd_cnt_o     out  CNT_W                selected counter, registered
//  cycle_o      out  CNT_W                live cycle counter
//  done_o       out  1                    cycle limit reached (sticky)
//  trc_valid_o  out  1                    trace FIFO non-empty
//  trc_ready_i  in   1                    consumer pops head when valid&ready
//  trc_cycle_o  out  CNT_W                head entry: cycle stamp
//  trc_pc_o     out  PC_W                 head entry: PC
//  trc_evt_o    out  NUM_EVT              head entry: event bits
//  trc_level_o  out  $clog2(TRACE_DEPTH)+1  FIFO occupancy, 0..TRACE_DEPTH
//  trc_ovf_o    out  1                    sticky: at least one entry dropped
// BEHAVIOUR
//  - Reset (rst_i=1 at edge): all counters, rd_cnt_o, done_o, trc_ovf_o=0; FIFO empty;
//    trc_valid_o=0, trc_level_o=0. Head data outputs are don't-care when empty.
//  - Priority per edge: rst_i > clear_i > normal operation. clear_i = same effect as reset.
//  - active = start_i & ~freeze_i & ~done_o. Only active cycles count or trace.
//  - Cycle counter: +1 on each active cycle. When it becomes MAX_CYCLES (MAX_CYCLES!=0),
//    done_o rises on that edge and stays 1 until rst_i/clear_i; counting then stops.
//  - Event counter k: +1 on active cycle with evt_i[k]=1; saturates at all-ones, never wraps.
//  - Cycle counter and drop counter also saturate at all-ones.
//  - Trace push: on active cycle with (|evt_i | pc_valid_i), write
//    {cycle value before increment, pc_i, evt_i}.
//  - FIFO: first-word-fall-through; head visible combinationally from storage.
//    Pop on trc_valid_o & trc_ready_i. Pointers wrap modulo TRACE_DEPTH.
//  - Full + push + pop same cycle: both occur, level unchanged, no drop.
//  - Full + push, no pop: entry discarded, drop counter +1, trc_ovf_o set (sticky).
//  - Empty + push + pop: no pop (valid=0); push occurs; level becomes 1.
//  - Pops continue while frozen or done; only pushes are gated.
//  - rd_cnt_o latency 1: at edge N it captures the value of the counter selected
//    by rd_sel_i before edge N's update. rd_sel_i: 0..NUM_EVT-1 = event counters,
//    NUM_EVT = cycle counter, NUM_EVT+1 = drop counter, other values = 0.
//  - rst_i or clear_i mid-operation: in-flight FIFO contents are lost; no partial state kept.
// STRUCTURE
//  - Package perf_pkg: EVT_STALL=0, EVT_FLUSH=1, EVT_RETIRE=2, EVT_BRANCH=3;
//    SEL_CYCLE/SEL_DROP offsets; trace entry struct {cycle, pc, evt}.
//  - Sub-module perf_trace_fifo: parametrised FWFT FIFO (WIDTH, DEPTH) with full,
//    empty, level and synchronous flush; top handles drop/overflow policy.
//  - Counter bank and read mux stay in the top level.
// TESTING
//  - Reset: rst_i=1 2 cycles -> all outputs 0, trc_valid_o=0, trc_level_o=0.
//  - Count: start_i=1, evt_i=4'b0001 on 3 cycles, 4'b0011 on 2 -> ctr0=5, ctr1=2;
//    rd_sel_i=0 gives 5 one cycle after selection.
//  - Limit: MAX_CYCLES=64, start_i=1 -> done_o rises when cycle_o=64; cycle_o holds 64.
//  - Overflow: DEPTH=16, trc_ready_i=0, pc_valid_i=1 for 20 cycles -> level=16,
//    trc_ovf_o=1, drop counter=4; then ready=1 -> first popped cycle stamp = 0.
//  - Full push+pop: FIFO full, pc_valid_i=1, trc_ready_i=1 -> level stays 16, no drop.
//  - Clear/saturate: CNT_W=4, evt_i[2]=1 for 20 cycles -> ctr2=15; clear_i pulse ->
//    all counters 0, FIFO empty, trc_ovf_o=0, done_o=0.

Source files
------------

// File: rtl/perf_pkg.sv
// perf_pkg: event indices, read-select offsets and trace entry layout for the perf monitor
package perf_pkg;
  localparam int EVT_STALL = 0;
  localparam int EVT_FLUSH = 1;
  localparam int EVT_RETIRE = 2;
  localparam int EVT_BRANCH = 3;
  localparam int SEL_CYCLE_OFS = 0;
  localparam int SEL_DROP_OFS = 1;
  localparam int TRC_CNT_W = 32;
  localparam int TRC_PC_W = 32;
  localparam int TRC_EVT_W = 4;
  typedef struct packed {
    logic [TRC_CNT_W-1:0] cycle;
    logic [TRC_PC_W-1:0]  pc;
    logic [TRC_EVT_W-1:0] evt;
  } trace_entry_t;
  function automatic int sel_cycle(input int num_evt);
    return num_evt + SEL_CYCLE_OFS;
  endfunction
  function automatic int sel_drop(input int num_evt);
    return num_evt + SEL_DROP_OFS;
  endfunction
endpackage

// File: rtl/perf_trace_fifo.sv
// perf_trace_fifo: first-word-fall-through FIFO with level and synchronous flush
module perf_trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [LW-1:0] lvl_q;
  logic do_push, do_pop;
  assign empty_o = lvl_q == '0;
  assign full_o = lvl_q == LW'(DEPTH);
  assign level_o = lvl_q;
  assign rdata_o = mem_q[rd_q];
  assign do_pop = pop_i & ~empty_o;
  // a full FIFO still accepts a push when the head leaves on the same edge
  assign do_push = push_i & (~full_o | do_pop);
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
      lvl_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(do_push);
      rd_q <= rd_q + AW'(do_pop);
      lvl_q <= lvl_q + LW'(do_push) - LW'(do_pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end
endmodule

// File: rtl/pipeline_perf_monitor.sv
// pipeline_perf_monitor: saturating event/cycle counters, read mux and PC/event trace FIFO
module pipeline_perf_monitor
  import perf_pkg::*;
#(
  parameter int NUM_EVT = 4,
  parameter int CNT_W = 32,
  parameter int PC_W = 32,
  parameter int TRACE_DEPTH = 16,
  parameter int MAX_CYCLES = 64
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           start_i,
  input  logic                           freeze_i,
  input  logic                           clear_i,
  input  logic [NUM_EVT-1:0]             evt_i,
  input  logic [PC_W-1:0]                pc_i,
  input  logic                           pc_valid_i,
  input  logic [$clog2(NUM_EVT+2)-1:0]   rd_sel_i,
  output logic [CNT_W-1:0]               rd_cnt_o,
  output logic [CNT_W-1:0]               cycle_o,
  output logic                           done_o,
  output logic                           trc_valid_o,
  input  logic                           trc_ready_i,
  output logic [CNT_W-1:0]               trc_cycle_o,
  output logic [PC_W-1:0]                trc_pc_o,
  output logic [NUM_EVT-1:0]             trc_evt_o,
  output logic [$clog2(TRACE_DEPTH):0]   trc_level_o,
  output logic                           trc_ovf_o
);
  localparam int SW = $clog2(NUM_EVT + 2);
  localparam int EW = CNT_W + PC_W + NUM_EVT;
  localparam logic [CNT_W-1:0] CMAX = '1;
  logic [CNT_W-1:0] cyc_q, cyc_d, drop_q, drop_d, rd_q, rd_d;
  logic [CNT_W-1:0] evt_q [NUM_EVT];
  logic [CNT_W-1:0] evt_d [NUM_EVT];
  logic done_q, done_d, ovf_q, ovf_d;
  logic active, push_req, pop, drop, full, empty;
  logic [EW-1:0] rdata;
  assign active = start_i & ~freeze_i & ~done_q;
  assign push_req = active & (|evt_i | pc_valid_i);
  assign pop = trc_valid_o & trc_ready_i;
  assign drop = push_req & full & ~pop;
  always_comb begin
    cyc_d = active && cyc_q != CMAX ? cyc_q + 1'b1 : cyc_q;
    done_d = done_q | (MAX_CYCLES != 0 && active && cyc_d == CNT_W'(MAX_CYCLES));
    drop_d = drop && drop_q != CMAX ? drop_q + 1'b1 : drop_q;
    ovf_d = ovf_q | drop;
    for (int k = 0; k < NUM_EVT; k++)
      evt_d[k] = active && evt_i[k] && evt_q[k] != CMAX ? evt_q[k] + 1'b1 : evt_q[k];
    rd_d = '0;
    for (int k = 0; k < NUM_EVT; k++)
      if (rd_sel_i == SW'(k)) rd_d = evt_q[k];
    if (rd_sel_i == SW'(sel_cycle(NUM_EVT))) rd_d = cyc_q;
    if (rd_sel_i == SW'(sel_drop(NUM_EVT))) rd_d = drop_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      cyc_q <= '0;
      drop_q <= '0;
      rd_q <= '0;
      done_q <= 1'b0;
      ovf_q <= 1'b0;
      for (int k = 0; k < NUM_EVT; k++) evt_q[k] <= '0;
    end else begin
      cyc_q <= cyc_d;
      drop_q <= drop_d;
      rd_q <= rd_d;
      done_q <= done_d;
      ovf_q <= ovf_d;
      for (int k = 0; k < NUM_EVT; k++) evt_q[k] <= evt_d[k];
    end
  end
  // entries carry the cycle stamp taken before this edge's increment
  perf_trace_fifo #(.WIDTH(EW), .DEPTH(TRACE_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (clear_i),
    .push_i  (push_req),
    .pop_i   (pop),
    .wdata_i ({cyc_q, pc_i, evt_i}),
    .rdata_o (rdata),
    .full_o  (full),
    .empty_o (empty),
    .level_o (trc_level_o)
  );
  assign {trc_cycle_o, trc_pc_o, trc_evt_o} = rdata;
  assign trc_valid_o = ~empty;
  assign rd_cnt_o = rd_q;
  assign cycle_o = cyc_q;
  assign done_o = done_q;
  assign trc_ovf_o = ovf_q;
endmodule

// File: tb/tb_pipeline_perf_monitor.sv
// tb_pipeline_perf_monitor: randomized checks against a queue-based reference model
module tb_pipeline_perf_monitor;
  logic clk = 1'b0;
  logic rst, start, freeze, clear, pcv, ready;
  logic [3:0] evt;
  logic [31:0] pc;
  logic [2:0] sel;
  logic [31:0] rd_cnt, cycle, tcyc, tpc;
  logic done, tv, ovf;
  logic [3:0] tevt;
  logic [4:0] lvl;
  logic [3:0] s_rd, s_cycle, s_tcyc, s_tevt;
  logic [31:0] s_tpc;
  logic s_done, s_tv, s_ovf;
  logic [4:0] s_lvl;
  int total = 0, bad = 0;
  typedef struct packed {logic [31:0] c; logic [31:0] p; logic [3:0] e;} ent_t;
  ent_t m_q[$];
  logic [31:0] m_cyc, m_drop, m_rd;
  logic [31:0] m_cnt [4];
  bit m_done, m_ovf;

  always #5 clk = ~clk;

  pipeline_perf_monitor dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .freeze_i(freeze), .clear_i(clear),
    .evt_i(evt), .pc_i(pc), .pc_valid_i(pcv), .rd_sel_i(sel), .rd_cnt_o(rd_cnt),
    .cycle_o(cycle), .done_o(done), .trc_valid_o(tv), .trc_ready_i(ready),
    .trc_cycle_o(tcyc), .trc_pc_o(tpc), .trc_evt_o(tevt), .trc_level_o(lvl), .trc_ovf_o(ovf)
  );

  pipeline_perf_monitor #(.CNT_W(4), .MAX_CYCLES(0)) dut_s (
    .clk_i(clk), .rst_i(rst), .start_i(start), .freeze_i(freeze), .clear_i(clear),
    .evt_i(evt), .pc_i(pc), .pc_valid_i(pcv), .rd_sel_i(sel), .rd_cnt_o(s_rd),
    .cycle_o(s_cycle), .done_o(s_done), .trc_valid_o(s_tv), .trc_ready_i(ready),
    .trc_cycle_o(s_tcyc), .trc_pc_o(s_tpc), .trc_evt_o(s_tevt), .trc_level_o(s_lvl),
    .trc_ovf_o(s_ovf)
  );

  // advance the reference model by one edge using the current inputs, then step the clock
  task automatic cyc1();
    logic [31:0] rdn;
    bit act, req, popm, fullm;
    if (rst || clear) begin
      m_cyc = 0; m_drop = 0; m_rd = 0; m_done = 0; m_ovf = 0;
      m_cnt = '{default: 0};
      m_q.delete();
    end else begin
      rdn = sel < 4 ? m_cnt[sel[1:0]] : sel == 4 ? m_cyc : sel == 5 ? m_drop : 32'd0;
      act = start && !freeze && !m_done;
      req = act && (evt != 0 || pcv);
      popm = m_q.size() > 0 && ready;
      fullm = m_q.size() == 16;
      if (popm) void'(m_q.pop_front());
      if (req) begin
        if (!fullm || popm) m_q.push_back(ent_t'{m_cyc, pc, evt});
        else begin
          if (m_drop != 32'hFFFF_FFFF) m_drop++;
          m_ovf = 1;
        end
      end
      if (act) begin
        for (int k = 0; k < 4; k++) if (evt[k] && m_cnt[k] != 32'hFFFF_FFFF) m_cnt[k]++;
        if (m_cyc != 32'hFFFF_FFFF) m_cyc++;
        if (m_cyc == 64) m_done = 1;
      end
      m_rd = rdn;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1; cyc1(); clear = 0;
  endtask

  task automatic test_reset();
    rst = 1; cyc1(); cyc1();
    total++; if (cycle !== 0) begin bad++; $display("FAIL reset_cycle got=%0d exp=0", cycle); end
    total++; if (done !== 0 || ovf !== 0) begin bad++; $display("FAIL reset_flags got=%b%b exp=00", done, ovf); end
    total++; if (tv !== 0 || lvl !== 0) begin bad++; $display("FAIL reset_fifo got=%b/%0d exp=0/0", tv, lvl); end
    total++; if (rd_cnt !== 0) begin bad++; $display("FAIL reset_rd got=%0d exp=0", rd_cnt); end
    rst = 0;
  endtask

  task automatic test_count();
    do_clear();
    start = 1; ready = 1; pcv = 0;
    evt = 4'b0001; repeat (3) cyc1();
    evt = 4'b0011; repeat (2) cyc1();
    start = 0; evt = 0; sel = 0; cyc1();
    total++; if (rd_cnt !== 5 || rd_cnt !== m_rd) begin bad++; $display("FAIL count_ctr0 got=%0d exp=5", rd_cnt); end
    sel = 1; cyc1();
    total++; if (rd_cnt !== 2 || rd_cnt !== m_rd) begin bad++; $display("FAIL count_ctr1 got=%0d exp=2", rd_cnt); end
    sel = 4; cyc1();
    total++; if (rd_cnt !== 5) begin bad++; $display("FAIL count_cycle got=%0d exp=5", rd_cnt); end
  endtask

  task automatic test_limit();
    do_clear();
    start = 1;
    for (int i = 0; i < 80 && !m_done; i++) begin
      evt = 4'($urandom); pcv = 1'($urandom); ready = 1'($urandom); pc = $urandom;
      cyc1();
      total++;
      if (cycle !== m_cyc || done !== m_done) begin
        bad++; $display("FAIL limit_step cyc=%0d done=%b exp %0d/%b", cycle, done, m_cyc, m_done);
      end
    end
    total++; if (cycle !== 64 || done !== 1) begin bad++; $display("FAIL limit_reach got=%0d/%b exp=64/1", cycle, done); end
    repeat (3) cyc1();
    total++; if (cycle !== 64 || done !== 1) begin bad++; $display("FAIL limit_hold got=%0d/%b exp=64/1", cycle, done); end
  endtask

  task automatic test_overflow();
    do_clear();
    start = 1; freeze = 0; ready = 0; pcv = 1; evt = 0;
    repeat (20) begin pc = $urandom; cyc1(); end
    start = 0; pcv = 0; sel = 5; cyc1();
    total++; if (lvl !== 16 || ovf !== 1) begin bad++; $display("FAIL ovf_level got=%0d/%b exp=16/1", lvl, ovf); end
    total++; if (rd_cnt !== 4) begin bad++; $display("FAIL ovf_drop got=%0d exp=4", rd_cnt); end
    total++; if (tv !== 1 || tcyc !== 0 || tpc !== m_q[0].p) begin
      bad++; $display("FAIL ovf_head got=%b/%0d/%h exp=1/0/%h", tv, tcyc, tpc, m_q[0].p); end
  endtask

  task automatic test_full_pushpop();
    start = 1; pcv = 1; ready = 1;
    repeat (3) begin
      pc = $urandom; cyc1();
      total++;
      if (lvl !== 16 || tcyc !== m_q[0].c || tpc !== m_q[0].p) begin
        bad++; $display("FAIL full_pp lvl=%0d head=%0d exp 16/%0d", lvl, tcyc, m_q[0].c);
      end
    end
    start = 0; ready = 0; sel = 5; cyc1();
    total++; if (rd_cnt !== 4) begin bad++; $display("FAIL full_pp_drop got=%0d exp=4", rd_cnt); end
  endtask

  task automatic test_random();
    do_clear();
    for (int i = 0; i < 300; i++) begin
      start = ($urandom % 8) != 0; freeze = ($urandom % 6) == 0; clear = ($urandom % 50) == 0;
      evt = 4'($urandom); pcv = 1'($urandom); ready = ($urandom % 3) == 0;
      sel = 3'($urandom_range(0, 7)); pc = $urandom;
      cyc1();
      total++;
      if (cycle !== m_cyc || done !== m_done || rd_cnt !== m_rd || ovf !== m_ovf) begin
        bad++; $display("FAIL rand_cnt i=%0d cyc=%0d done=%b rd=%0d ovf=%b exp %0d/%b/%0d/%b",
                        i, cycle, done, rd_cnt, ovf, m_cyc, m_done, m_rd, m_ovf);
      end
      total++;
      if (lvl !== 5'(m_q.size()) || tv !== (m_q.size() > 0)) begin
        bad++; $display("FAIL rand_lvl i=%0d got=%0d exp=%0d", i, lvl, m_q.size());
      end else if (m_q.size() > 0) begin
        total++;
        if ({tcyc, tpc, tevt} !== m_q[0]) begin
          bad++; $display("FAIL rand_head i=%0d got=%0d/%h/%b exp=%0d/%h/%b",
                          i, tcyc, tpc, tevt, m_q[0].c, m_q[0].p, m_q[0].e);
        end
      end
    end
    clear = 0;
  endtask

  task automatic test_saturate();
    do_clear();
    start = 1; freeze = 0; evt = 4'b0100; pcv = 0; ready = 1;
    repeat (20) cyc1();
    start = 0; evt = 0; sel = 2; cyc1();
    total++; if (s_rd !== 15 || s_cycle !== 15) begin bad++; $display("FAIL sat_ctr2 got=%0d/%0d exp=15/15", s_rd, s_cycle); end
    total++; if (rd_cnt !== m_rd || rd_cnt !== 20) begin bad++; $display("FAIL sat_wide got=%0d exp=20", rd_cnt); end
    do_clear();
    cyc1();
    total++; if (s_rd !== 0 || s_cycle !== 0 || s_lvl !== 0 || s_ovf !== 0 || s_done !== 0) begin
      bad++; $display("FAIL sat_clear got=%0d/%0d/%0d/%b/%b exp=0", s_rd, s_cycle, s_lvl, s_ovf, s_done); end
    total++; if (cycle !== 0 || lvl !== 0 || tv !== 0 || ovf !== 0 || done !== 0) begin
      bad++; $display("FAIL main_clear got=%0d/%0d/%b/%b/%b exp=0", cycle, lvl, tv, ovf, done); end
  endtask

  initial begin
    rst = 1; start = 0; freeze = 0; clear = 0; pcv = 0; ready = 0; evt = 0; pc = 0; sel = 0;
    test_reset();
    test_count();
    test_limit();
    test_overflow();
    test_full_pushpop();
    test_random();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
